axis_kbd_fifo: RTL and testbench
================================

// Module: axis_kbd_fifo
// PURPOSE
//  Byte-wide AXI-Stream FIFO between the PS/2 keyboard AXIS source and the CPU-side AXIS interface.
//  Buffers scan-code bursts while software is slow to poll.
//  Offers either lossless backpressure or drop-on-full (PS/2 cannot be stalled).
//  Reports fill level and a sticky overflow flag for status/IRQ logic.
// PARAMETERS
//  DEPTH           16  entries; power of 2, >= 2
//  DROP_WHEN_FULL  1   1: s_axis_tready_o tied 1, bytes arriving while full are discarded; 0: tready = !full
// PORTS
//  axis_aclk_i      in   1            single clock, all logic rising-edge
//  axis_aresetn_i   in   1            reset, asynchronous, active-low
//  s_axis_tvalid_i  in   1            upstream byte valid
//  s_axis_tready_o  out  1            upstream ready
//  s_axis_tdata_i   in   8            upstream byte
//  m_axis_tvalid_o  out  1            downstream byte valid
//  m_axis_tready_i  in   1            downstream ready
//  m_axis_tdata_o   out  8            downstream byte (head of FIFO)
//  flush_i          in   1            synchronous clear of contents and overflow flag
//  level_o          out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH
//  overflow_o       out  1            sticky: at least one byte dropped since reset/flush
// BEHAVIOUR
//  - Reset (axis_aresetn_i=0, async): wr_ptr=rd_ptr=0, count=0.
//    Outputs during and after reset: m_axis_tvalid_o=0, level_o=0, overflow_o=0.
//    m_axis_tdata_o=8'h00 (storage array not reset; the head output reads 0 while empty).
//    s_axis_tready_o=1 (empty; both modes).
//  - Storage: DEPTH x 8 register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
//    Separate count register; full = (count==DEPTH), empty = (count==0).
//  - Push: s_axis_tvalid_i & s_axis_tready_o & !full. Data written at mem[wr_ptr], wr_ptr++.
//  - Pop: m_axis_tvalid_o & m_axis_tready_i. rd_ptr++.
//  - m_axis_tvalid_o = !empty. m_axis_tdata_o = mem[rd_ptr] when !empty, else 8'h00.
//    All three derive only from registers, never combinationally from s_axis_*.
//  - Latency: byte pushed on edge N is visible on m_axis with tvalid=1 right after edge N (1 cycle). No bypass.
//  - AXIS rule: while m_axis_tvalid_o=1 and m_axis_tready_i=0, tdata/tvalid hold stable.
//  - Simultaneous push+pop with 0<count<DEPTH: both occur, count unchanged.
//  - Push+pop when empty: only the push occurs (tvalid was 0); count 0->1.
//  - Full, DROP_WHEN_FULL=0: s_axis_tready_o=0, upstream holds. A pop that cycle frees space;
//    tready returns to 1 the next cycle (no same-cycle full pass-through).
//  - Full, DROP_WHEN_FULL=1: tvalid while full discards the byte, sets overflow_o=1 on that edge.
//    A pop that same cycle does not rescue the byte. Pointers and count are unchanged by the drop.
//  - overflow_o is never set when DROP_WHEN_FULL=0.
//  - level_o = count register (registered, updates on the edge of push/pop).
//  - flush_i=1: on the next edge count=0, pointers=0, overflow_o=0.
//    Flush has priority over any push/pop in the same cycle; those bytes are lost.
//  - Reset mid-transfer: contents discarded immediately. No byte is presented after reset release
//    until a new push.
// TESTING
//  1 Reset: hold aresetn=0 with s_tvalid=1 -> m_tvalid=0, level=0, overflow=0, tready=1.
//    Release -> first push of 8'h1C appears on m_tdata at the next cycle.
//  2 Ordering: push 8'h1C,8'hF0,8'h1C with m_tready=0 -> level=3.
//    Then m_tready=1 -> bytes out 1C,F0,1C in order, level 3->0, tvalid drops after third.
//  3 Full/drop (DEPTH=16, DROP=1): push 17 bytes 0x00..0x10, no pop -> level=16, overflow=1.
//    Drain yields 0x00..0x0F (0x10 lost).
//  4 Full/backpressure (DROP=0): fill 16 -> tready=0, held byte 0xAA not lost.
//    One pop -> tready=1 next cycle, 0xAA accepted, read order preserved.
//  5 Concurrency: level=5, push+pop 20 consecutive cycles -> level stays 5, pointers wrap past 15, data intact.
//  6 Flush with simultaneous push and overflow=1 -> next cycle level=0, overflow=0, m_tvalid=0.

Source files
------------

// File: rtl/axis_kbd_fifo.sv
// axis_kbd_fifo: byte-wide AXI-Stream FIFO buffering PS/2 scan codes, lossless or drop-on-full
module axis_kbd_fifo #(
    parameter int DEPTH          = 16,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                       axis_aclk_i,
    input  logic                       axis_aresetn_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [7:0]                 s_axis_tdata_i,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic [7:0]                 m_axis_tdata_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop, drop;

    assign full            = count_q == LW'(DEPTH);
    assign empty           = count_q == '0;
    assign s_axis_tready_o = DROP_WHEN_FULL || !full;
    assign push            = s_axis_tvalid_i && s_axis_tready_o && !full;
    assign pop             = !empty && m_axis_tready_i;
    assign drop            = DROP_WHEN_FULL && s_axis_tvalid_i && full;

    assign m_axis_tvalid_o = !empty;
    assign m_axis_tdata_o  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign level_o         = count_q;
    assign overflow_o      = overflow_q;

    // next state; flush discards everything including a same-cycle push, pop or drop
    always_comb begin
        wr_ptr_d   = flush_i ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = flush_i ? '0 : rd_ptr_q + AW'(pop);
        count_d    = flush_i ? '0 : count_q + LW'(push) - LW'(pop);
        overflow_d = !flush_i && (overflow_q || drop);
    end

    // pointer, count and sticky overflow state
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // storage is not reset; an empty FIFO masks the head to zero instead
    always_ff @(posedge axis_aclk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= s_axis_tdata_i;
    end
endmodule

// File: tb/tb_axis_kbd_fifo.sv
// tb_axis_kbd_fifo: checks drop-on-full and backpressure FIFO variants against a queue model
module tb_axis_kbd_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tv = 1'b0, mr = 1'b0, fl = 1'b0;
    logic [7:0] td = 8'h00;
    logic       r1, v1, o1, r0, v0, o0;
    logic [7:0] d1, d0;
    logic [4:0] l1, l0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    bit         ov1, ov0;
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    axis_kbd_fifo #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b1)) u_drop (
        .axis_aclk_i(clk), .axis_aresetn_i(rst_n),
        .s_axis_tvalid_i(tv), .s_axis_tready_o(r1), .s_axis_tdata_i(td),
        .m_axis_tvalid_o(v1), .m_axis_tready_i(mr), .m_axis_tdata_o(d1),
        .flush_i(fl), .level_o(l1), .overflow_o(o1)
    );

    axis_kbd_fifo #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b0)) u_bp (
        .axis_aclk_i(clk), .axis_aresetn_i(rst_n),
        .s_axis_tvalid_i(tv), .s_axis_tready_o(r0), .s_axis_tdata_i(td),
        .m_axis_tvalid_o(v0), .m_axis_tready_i(mr), .m_axis_tdata_o(d0),
        .flush_i(fl), .level_o(l0), .overflow_o(o0)
    );

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        int         el;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s actual=%0d required=%0d", n, a, e);
    endtask

    task automatic clear_models();
        q1.delete();
        q0.delete();
        ov1 = 0;
        ov0 = 0;
    endtask

    // one clock edge with current inputs; models advance from their pre-edge contents
    task automatic tick();
        bit full1, full0, any1, any0;
        full1 = q1.size() == DEPTH;
        full0 = q0.size() == DEPTH;
        any1  = q1.size() != 0;
        any0  = q0.size() != 0;
        if (fl) clear_models();
        else begin
            if (mr && any1) void'(q1.pop_front());
            if (tv && !full1) q1.push_back(td);
            if (tv && full1) ov1 = 1;
            if (mr && any0) void'(q0.pop_front());
            if (tv && !full0) q0.push_back(td);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("m1_tvalid", int'(v1), int'(q1.size() != 0));
        chk("m1_tdata", int'(d1), q1.size() != 0 ? int'(q1[0]) : 0);
        chk("m1_level", int'(l1), q1.size());
        chk("m1_ovf", int'(o1), int'(ov1));
        chk("m1_tready", int'(r1), 1);
        chk("m0_tvalid", int'(v0), int'(q0.size() != 0));
        chk("m0_tdata", int'(d0), q0.size() != 0 ? int'(q0[0]) : 0);
        chk("m0_level", int'(l0), q0.size());
        chk("m0_ovf", int'(o0), int'(ov0));
        chk("m0_tready", int'(r0), int'(q0.size() != DEPTH));
    endtask

    logic [7:0] exp_drain[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1};
        tbl[1] = '{1'b1, 8'hF0, 1'b0, 1'b1, 8'h1C, 2};
        tbl[2] = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 3};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hF0, 2};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1C, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

        // reset held with upstream valid asserted
        rst_n = 1'b0;
        tv = 1'b1;
        td = 8'h1C;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid1", int'(v1), 0);
        chk("rst_level1", int'(l1), 0);
        chk("rst_ovf1", int'(o1), 0);
        chk("rst_tready1", int'(r1), 1);
        chk("rst_tdata1", int'(d1), 0);
        chk("rst_tvalid0", int'(v0), 0);
        chk("rst_tready0", int'(r0), 1);
        rst_n = 1'b1;

        // first push after release, ordering, empty push+pop, hold under stall
        for (int i = 0; i < 9; i++) begin
            tv = tbl[i].tv;
            td = tbl[i].td;
            mr = tbl[i].mr;
            tick();
            chk($sformatf("tbl%0d_tvalid1", i), int'(v1), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_tdata1", i), int'(d1), int'(tbl[i].ed));
            chk($sformatf("tbl%0d_level1", i), int'(l1), tbl[i].el);
            chk($sformatf("tbl%0d_tvalid0", i), int'(v0), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_tdata0", i), int'(d0), int'(tbl[i].ed));
            chk($sformatf("tbl%0d_level0", i), int'(l0), tbl[i].el);
            chk($sformatf("tbl%0d_ovf1", i), int'(o1), 0);
        end

        // fill with 17 bytes, no pop
        mr = 1'b0;
        tv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            td = 8'(i);
            tick();
        end
        chk("full_level1", int'(l1), 16);
        chk("full_ovf1", int'(o1), 1);
        chk("full_tready1", int'(r1), 1);
        chk("full_level0", int'(l0), 16);
        chk("full_ovf0", int'(o0), 0);
        chk("full_tready0", int'(r0), 0);
        chk("full_head1", int'(d1), 8'h00);

        // backpressured byte held, then one pop frees a slot
        td = 8'hAA;
        tick();
        chk("hold_tready0", int'(r0), 0);
        chk("hold_level0", int'(l0), 16);
        mr = 1'b1;
        tick();
        chk("pop_tready0", int'(r0), 1);
        chk("pop_level0", int'(l0), 15);
        chk("pop_level1", int'(l1), 15);
        chk("pop_head0", int'(d0), 8'h01);
        mr = 1'b0;
        tick();
        chk("acc_level0", int'(l0), 16);
        chk("acc_tready0", int'(r0), 0);
        chk("acc_level1", int'(l1), 16);
        for (int i = 0; i < 15; i++) exp_drain[i] = 8'(i + 1);
        exp_drain[15] = 8'hAA;
        tv = 1'b0;
        mr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_d1", i), int'(d1), int'(exp_drain[i]));
            chk($sformatf("drain%0d_d0", i), int'(d0), int'(exp_drain[i]));
            tick();
        end
        chk("drained_tvalid1", int'(v1), 0);
        chk("drained_tvalid0", int'(v0), 0);
        chk("drained_ovf_sticky", int'(o1), 1);

        // flush with concurrent push and pop while overflow is set
        mr = 1'b0;
        tv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            td = 8'h30 + 8'(i);
            tick();
        end
        fl = 1'b1;
        mr = 1'b1;
        tick();
        chk("flush_level1", int'(l1), 0);
        chk("flush_ovf1", int'(o1), 0);
        chk("flush_tvalid1", int'(v1), 0);
        chk("flush_level0", int'(l0), 0);
        chk("flush_tvalid0", int'(v0), 0);
        fl = 1'b0;
        tv = 1'b0;
        mr = 1'b0;
        tick();
        check_model();

        // steady push+pop at level 5 wraps the pointers
        tv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            td = 8'h60 + 8'(i);
            tick();
        end
        mr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            td = 8'h80 + 8'(i);
            tick();
            chk($sformatf("conc%0d_level1", i), int'(l1), 5);
            chk($sformatf("conc%0d_level0", i), int'(l0), 5);
            check_model();
        end

        // asynchronous reset mid-transfer empties immediately
        tv = 1'b0;
        mr = 1'b0;
        rst_n = 1'b0;
        #2;
        clear_models();
        chk("arst_tvalid1", int'(v1), 0);
        chk("arst_level1", int'(l1), 0);
        chk("arst_tdata1", int'(d1), 0);
        chk("arst_level0", int'(l0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_model();

        // random traffic against the queue model
        for (int i = 0; i < 800; i++) begin
            tv = $urandom_range(3, 0) != 0;
            td = 8'($urandom);
            mr = (i % 200) < 100 ? $urandom_range(3, 0) == 0 : $urandom_range(3, 0) != 0;
            fl = $urandom_range(79, 0) == 0;
            tick();
            check_model();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
